// File: rtl/reg_bank_sequencer_if.sv
// Select/handshake bundle between the register-bank sequencer and its peers.
// The master side is the sequencer; the slave side is fetch plus bank/ALU.
interface reg_bank_sequencer_if;
    logic       instr_valid;
    logic [7:0] instr_byte;
    logic       instr_ready;
    logic       acc_sel;
    logic [2:0] source_sel;
    logic [3:0] destination_sel;
    logic [1:0] alu_b_sel;
    logic [1:0] bank_out_sel;
    logic [7:0] bank_data_in;
    logic [2:0] alu_op;
    logic       out_strobe;
    logic       busy;
    logic       halted;

    modport master (
        input  instr_valid, instr_byte,
        output instr_ready, acc_sel, source_sel, destination_sel,
        output alu_b_sel, bank_out_sel, bank_data_in, alu_op,
        output out_strobe, busy, halted
    );

    modport slave (
        output instr_valid, instr_byte,
        input  instr_ready, acc_sel, source_sel, destination_sel,
        input  alu_b_sel, bank_out_sel, bank_data_in, alu_op,
        input  out_strobe, busy, halted
    );
endinterface

// File: rtl/reg_bank_sequencer.sv
// Multi-cycle decode/sequence FSM driving the register bank selects and ALU op.
// Optional RETIRE_CNT_EN adds a 16-bit retired-instruction counter port.
module reg_bank_sequencer #(
    parameter logic [7:0] HLT_OPCODE = 8'hFF,
    parameter logic [5:0] OUT_PREFIX = 6'b110000
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_bank_sequencer_if.master bus
`ifdef RETIRE_CNT_EN
    ,
    output logic [15:0]          retired_count
`endif
);

    typedef enum logic [2:0] {FETCH, DECODE, IMM, EXEC, HALT} state_t;

    state_t     state, state_n;
    logic [7:0] ir, ir_n;
    logic [7:0] data_q, data_n;
    logic       imm_full, imm_full_n;
    logic       ready_q, ready_n;
    logic       acc_q, acc_n;
    logic       strobe_q, strobe_n;
    logic       busy_q, busy_n;
    logic       halted_q, halted_n;
    logic [2:0] src_q, src_n;
    logic [2:0] aluop_q, aluop_n;
    logic [3:0] dst_q, dst_n;
    logic [1:0] bsel_q, bsel_n;
    logic [1:0] osel_q, osel_n;
    logic       is_mov, is_mvi, is_alu, is_hlt, is_out;
    logic       hs;

    always_comb begin
        is_hlt = (ir == HLT_OPCODE);
        is_mov = (ir[7:6] == 2'b00);
        is_mvi = (ir[7:6] == 2'b01);
        is_alu = (ir[7:6] == 2'b10);
        is_out = !is_hlt && (ir[7:2] == OUT_PREFIX);
        hs     = bus.instr_valid && ready_q;
    end

    // IMM keeps one extra not-ready cycle after the immediate handshake so
    // MVI reaches EXEC with the same two-cycle latency as a plain opcode.
    always_comb begin
        state_n    = state;
        ir_n       = ir;
        data_n     = data_q;
        imm_full_n = imm_full;
        unique case (state)
            FETCH: begin
                if (hs) begin
                    ir_n    = bus.instr_byte;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                imm_full_n = 1'b0;
                if (is_mvi)      state_n = IMM;
                else if (is_hlt) state_n = HALT;
                else             state_n = EXEC;
            end
            IMM: begin
                if (imm_full) begin
                    state_n = EXEC;
                end else if (hs) begin
                    data_n     = bus.instr_byte;
                    imm_full_n = 1'b1;
                end
            end
            EXEC:    state_n = FETCH;
            HALT:    state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    always_comb begin
        ready_n  = (state_n == FETCH) || (state_n == IMM && !imm_full_n);
        busy_n   = (state_n != FETCH);
        halted_n = (state_n == HALT);
        acc_n    = 1'b0;
        strobe_n = 1'b0;
        src_n    = 3'b000;
        aluop_n  = 3'b000;
        dst_n    = 4'b0000;
        bsel_n   = 2'b00;
        osel_n   = 2'b00;
        if (state_n == EXEC) begin
            if (is_mov) begin
                src_n = {1'b0, ir[3:2]};
                dst_n = 4'b0001 << ir[5:4];
                acc_n = 1'b1;
            end else if (is_mvi) begin
                src_n = 3'b100;
                dst_n = 4'b0001 << ir[5:4];
                acc_n = 1'b1;
            end else if (is_alu) begin
                aluop_n = ir[5:3];
                bsel_n  = ir[2:1];
                dst_n   = 4'b0001;
            end else if (is_out) begin
                osel_n   = ir[1:0];
                strobe_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            ir       <= 8'h00;
            data_q   <= 8'h00;
            imm_full <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            acc_q    <= 1'b0;
            strobe_q <= 1'b0;
            src_q    <= 3'b000;
            aluop_q  <= 3'b000;
            dst_q    <= 4'b0000;
            bsel_q   <= 2'b00;
            osel_q   <= 2'b00;
        end else begin
            state    <= state_n;
            ir       <= ir_n;
            data_q   <= data_n;
            imm_full <= imm_full_n;
            ready_q  <= ready_n;
            busy_q   <= busy_n;
            halted_q <= halted_n;
            acc_q    <= acc_n;
            strobe_q <= strobe_n;
            src_q    <= src_n;
            aluop_q  <= aluop_n;
            dst_q    <= dst_n;
            bsel_q   <= bsel_n;
            osel_q   <= osel_n;
        end
    end

    assign bus.instr_ready     = ready_q;
    assign bus.busy            = busy_q;
    assign bus.halted          = halted_q;
    assign bus.acc_sel         = acc_q;
    assign bus.out_strobe      = strobe_q;
    assign bus.source_sel      = src_q;
    assign bus.alu_op          = aluop_q;
    assign bus.destination_sel = dst_q;
    assign bus.alu_b_sel       = bsel_q;
    assign bus.bank_out_sel    = osel_q;
    assign bus.bank_data_in    = data_q;

`ifdef RETIRE_CNT_EN
    logic retire;
    assign retire = (state_n == EXEC) || (state_n == HALT && state != HALT);

    always_ff @(posedge clk) begin
        if (reset)       retired_count <= 16'h0000;
        else if (retire) retired_count <= retired_count + 16'd1;
    end
`endif

endmodule
